fb_write_sender: RTL and testbench

CPU-domain transmitter for the frame-buffer write channel into the pixel-domain CDC synchronizer. The receiving end samples address, data and write-enable as plain levels and detects the write-enable rising edge, without any handshake. This block buffers CPU pixel writes in a FIFO and replays them as stable-address/stable-data write-enable pulses framed by setup and gap intervals. The receiver therefore never samples a changing bus while write-enable is high, and never misses an edge.

---
 rtl/fb_write_sender.sv | 179 +++++++++++++++++
 tb/tb_fb_write_sender.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_sender.sv
// CPU-domain sender for the frame-buffer write channel: FIFO-buffered writes replayed as framed fb_we strobes.
// Optional macro FB_ACK_EN adds a toggle-ack input that ends each strobe, with a timeout flag.
module fb_write_sender #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                            clk_cpu_fast,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ADDR_W-1:0]               in_addr,
    input  logic [DATA_W-1:0]               in_data,
    output logic [ADDR_W-1:0]               fb_addr,
    output logic [DATA_W-1:0]               fb_data,
    output logic                            fb_we,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
`ifdef FB_ACK_EN
    input  logic                            fb_ack_tgl,
    output logic                            ack_err,
`endif
    output logic                            overflow,
    input  logic                            clr_overflow
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = AW + 1;
    localparam int unsigned ENT_W   = ADDR_W + DATA_W;
    localparam int unsigned MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned MAX_SHG = (MAX_SH > GAP_CYC) ? MAX_SH : GAP_CYC;
    localparam int unsigned CNT_MAX = (MAX_SHG > ACK_TIMEOUT) ? MAX_SHG : ACK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [ENT_W-1:0]   mem [FIFO_DEPTH];
    logic [LVL_W-1:0]   wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, level_next;
    logic               empty_c, full_c, push_c, pop_c, ack_timeout_c;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty_c     = (wr_ptr == rd_ptr);
    assign full_c      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_c      = in_valid && !full_c;
    assign wr_ptr_next = wr_ptr + LVL_W'(push_c);
    assign rd_ptr_next = rd_ptr + LVL_W'(pop_c);
    assign level_next  = wr_ptr_next - rd_ptr_next;

`ifdef FB_ACK_EN
    (* ASYNC_REG = "TRUE" *) logic [1:0] ack_sync_q;
    logic ack_seen;
    logic ack_got_c;

    assign ack_got_c = (ack_sync_q[1] != ack_seen);

    // Ack synchronizer, per-strobe reference capture and sticky timeout flag
    always_ff @(posedge clk_cpu_fast or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_q <= '0;
            ack_seen   <= 1'b0;
            ack_err    <= 1'b0;
        end else begin
            ack_sync_q <= {ack_sync_q[0], fb_ack_tgl};
            if (state == SETUP && state_next == STROBE) ack_seen <= ack_sync_q[1];
            if (ack_timeout_c)     ack_err <= 1'b1;
            else if (clr_overflow) ack_err <= 1'b0;
        end
    end
`endif

    // Next-state and counter logic
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        pop_c         = 1'b0;
        ack_timeout_c = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_c) begin
                    pop_c      = 1'b1;
                    state_next = SETUP;
                    cnt_next   = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_next = STROBE;
`ifdef FB_ACK_EN
                    cnt_next   = '0;
`else
                    cnt_next   = CNT_W'(HOLD_CYC - 1);
`endif
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            STROBE: begin
`ifdef FB_ACK_EN
                // cnt counts elapsed strobe cycles minus one
                if (ack_got_c && cnt >= CNT_W'(HOLD_CYC - 1)) begin
                    state_next = GAP;
                    cnt_next   = CNT_W'(GAP_CYC - 1);
                end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_next    = GAP;
                    cnt_next      = CNT_W'(GAP_CYC - 1);
                    ack_timeout_c = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
`else
                if (cnt == '0) begin
                    state_next = GAP;
                    cnt_next   = CNT_W'(GAP_CYC - 1);
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
`endif
            end
            GAP: begin
                if (cnt == '0) begin
                    if (!empty_c) begin
                        pop_c      = 1'b1;
                        state_next = SETUP;
                        cnt_next   = CNT_W'(SETUP_CYC - 1);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_cpu_fast or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
        end else if (push_c) begin
            mem[wr_ptr[AW-1:0]] <= {in_addr, in_data};
        end
    end

    // Control, status and output registers
    always_ff @(posedge clk_cpu_fast or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            fifo_level <= level_next;
            in_ready   <= (level_next != LVL_W'(FIFO_DEPTH));
            busy       <= (state_next != IDLE) || (level_next != '0);
            fb_we      <= (state_next == STROBE);
            if (pop_c) {fb_addr, fb_data} <= mem[rd_ptr[AW-1:0]];
            if (in_valid && full_c) overflow <= 1'b1;
            else if (clr_overflow)  overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fb_write_sender.sv
// Directed bench for fb_write_sender: framing, FIFO fill/overflow, push+pop, reset, optional ack mode.
module tb_fb_write_sender;

    logic        clk_cpu_fast = 1'b0;
    logic        rst_n        = 1'b0;
    logic        in_valid     = 1'b0;
    logic        in_ready;
    logic [11:0] in_addr      = '0;
    logic [11:0] in_data      = '0;
    logic [11:0] fb_addr;
    logic [11:0] fb_data;
    logic        fb_we;
    logic        busy;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        clr_overflow = 1'b0;
`ifdef FB_ACK_EN
    logic        fb_ack_tgl;
    logic        ack_err;
    logic        auto_tgl = 1'b0;
    logic        man_tgl  = 1'b0;
    assign fb_ack_tgl = auto_tgl ^ man_tgl;
`endif

    int          n_checks = 0;
    int          n_err    = 0;
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    int          rise_t[$];
    int          last_width = 0;
    bit          chk_width  = 1'b1;
    bit          auto_en    = 1'b1;

    fb_write_sender dut (
        .clk_cpu_fast (clk_cpu_fast),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_we        (fb_we),
        .busy         (busy),
        .fifo_level   (fifo_level),
`ifdef FB_ACK_EN
        .fb_ack_tgl   (fb_ack_tgl),
        .ack_err      (ack_err),
`endif
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk_cpu_fast = ~clk_cpu_fast;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_cpu_fast);
        #1;
    endtask

    task automatic push(input logic [11:0] a, input logic [11:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        if (in_ready) exp_q.push_back({a, d});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && busy; k++) tick();
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    task automatic compare_strobes(input int base, input bit chk_period);
        check("n_strobes", 32'(got_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            check("strobe_order", 32'(got_q[base+i]), 32'(exp_q[i]));
            if (chk_period && i > 0)
                check("strobe_period", 32'(rise_t[base+i] - rise_t[base+i-1]), 32'd5);
        end
        exp_q.delete();
    endtask

    // Strobe monitor: records strobes, widths, and checks the bus only moves in quiet gaps
    initial begin : monitor
        logic [23:0] prev_ad = '0;
        logic        prev_we = 1'b0;
        int          low_cnt = 100;
        int          hi_cnt  = 0;
        int          cyc     = 0;
        forever begin
            @(posedge clk_cpu_fast);
            #1;
            cyc++;
            if (!rst_n) begin
                low_cnt = 100;
                hi_cnt  = 0;
            end else begin
                if ({fb_addr, fb_data} != prev_ad) begin
                    check("bus_change_window",
                          32'((!prev_we && !fb_we && low_cnt >= 2) ? 1 : 0), 32'd1);
`ifdef FB_ACK_EN
                    if (auto_en) auto_tgl = ~auto_tgl;
`endif
                end
                if (fb_we && !prev_we) begin
                    got_q.push_back({fb_addr, fb_data});
                    rise_t.push_back(cyc);
                    hi_cnt = 1;
                end else if (fb_we) begin
                    hi_cnt++;
                end
                if (!fb_we && prev_we) begin
                    last_width = hi_cnt;
                    if (chk_width) check("we_width", 32'(hi_cnt), 32'd2);
                end
                low_cnt = fb_we ? 0 : ((low_cnt < 100) ? low_cnt + 1 : low_cnt);
            end
            prev_ad = {fb_addr, fb_data};
            prev_we = fb_we;
        end
    end

    initial begin : main
        int base;
        int acc;

        // Reset values
        tick(); tick();
        rst_n = 1'b1;
        check("rst_fb_addr", 32'(fb_addr), 32'h0);
        check("rst_fb_data", 32'(fb_data), 32'h0);
        check("rst_fb_we", 32'(fb_we), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
`ifdef FB_ACK_EN
        check("rst_ack_err", 32'(ack_err), 32'h0);
`endif
        tick();

        // Single write: pushed at edge T
        base = got_q.size();
        push(12'h123, 12'hABC);
        check("t_level", 32'(fifo_level), 32'd1);
        check("t_busy", 32'(busy), 32'd1);
        check("t_we", 32'(fb_we), 32'd0);
        tick();
        check("t1_addr", 32'(fb_addr), 32'h123);
        check("t1_data", 32'(fb_data), 32'hABC);
        check("t1_we", 32'(fb_we), 32'd0);
        check("t1_level", 32'(fifo_level), 32'd0);
        tick();
        check("t2_we", 32'(fb_we), 32'd1);
        tick();
        check("t3_we", 32'(fb_we), 32'd1);
        check("t3_addr", 32'(fb_addr), 32'h123);
        tick();
        check("t4_we", 32'(fb_we), 32'd0);
        tick();
        check("t5_we", 32'(fb_we), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        tick();
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_addr", 32'(fb_addr), 32'h123);
        check("t6_data", 32'(fb_data), 32'hABC);
        compare_strobes(base, 1'b0);

        // Continuous pushes while draining: 20 accepted before full (net +4 per 5 cycles)
        base = got_q.size();
        acc  = 0;
        for (int k = 0; k < 40 && in_ready; k++) begin
            in_valid = 1'b1;
            in_addr  = 12'(12'h200 + k);
            in_data  = 12'(12'h800 + 3 * k);
            exp_q.push_back({in_addr, in_data});
            acc++;
            tick();
        end
        check("fill_accepted", 32'(acc), 32'd20);
        check("fill_level", 32'(fifo_level), 32'd16);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        in_addr = 12'hFFF;
        in_data = 12'hFFF;
        tick();
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level", 32'(fifo_level), 32'd16);
        clr_overflow = 1'b1;
        tick();
        check("ovf_set_wins", 32'(overflow), 32'd1);
        check("ovf_no_bypass_level", 32'(fifo_level), 32'd15);
        check("ovf_ready_after_pop", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick();
        check("ovf_cleared", 32'(overflow), 32'd0);
        clr_overflow = 1'b0;
        wait_idle(200);
        compare_strobes(base, 1'b1);

        // Push and pop in the same cycle at level 3
        base = got_q.size();
        push(12'h301, 12'h0A1);
        push(12'h302, 12'h0A2);
        push(12'h303, 12'h0A3);
        push(12'h304, 12'h0A4);
        check("pp_level_pre", 32'(fifo_level), 32'd3);
        tick(); tick();
        check("pp_level_hold", 32'(fifo_level), 32'd3);
        push(12'h305, 12'h0A5);
        check("pp_level_same", 32'(fifo_level), 32'd3);
        wait_idle(100);
        compare_strobes(base, 1'b1);

        // Reset in the middle of a strobe with three entries queued
        base = got_q.size();
        push(12'h401, 12'h0B1);
        push(12'h402, 12'h0B2);
        push(12'h403, 12'h0B3);
        push(12'h404, 12'h0B4);
        check("rstop_we_pre", 32'(fb_we), 32'd1);
        check("rstop_level_pre", 32'(fifo_level), 32'd3);
        rst_n = 1'b0;
        #1;
        check("rstop_we_async", 32'(fb_we), 32'd0);
        check("rstop_level_async", 32'(fifo_level), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        check("rstop_level_post", 32'(fifo_level), 32'd0);
        check("rstop_busy_post", 32'(busy), 32'd0);
        check("rstop_strobes", 32'(got_q.size() - base), 32'd1);
        exp_q.delete();

`ifdef FB_ACK_EN
        // Ack toggled four edges after the strobe rises: 5 + 2 sync cycles high
        chk_width = 1'b0;
        auto_en   = 1'b0;
        push(12'h555, 12'h0AA);
        for (int k = 0; k < 10 && !fb_we; k++) tick();
        check("ack_rise", 32'(fb_we), 32'd1);
        for (int k = 0; k < 4; k++) tick();
        man_tgl = ~man_tgl;
        wait_idle(60);
        check("ack_width", 32'(last_width), 32'd7);
        check("ack_no_err", 32'(ack_err), 32'd0);
        // No ack: strobe times out after ACK_TIMEOUT cycles
        push(12'h556, 12'h0AB);
        wait_idle(60);
        check("ack_to_width", 32'(last_width), 32'd16);
        check("ack_to_err", 32'(ack_err), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ack_err_clr", 32'(ack_err), 32'd0);
        exp_q.delete();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
